// File: rtl/sccpu_dbus_pkg.sv
// Data-bus address map and timer field layout shared by
// the single-cycle CPU data-side bus and its timer.
package sccpu_dbus_pkg;

  localparam logic [31:0] RAM_BASE        = 32'h0000_0000;
  localparam logic [31:0] RAM_LIMIT       = 32'h0000_0FFF;
  localparam logic [31:0] LED_ADDR        = 32'h0000_7F00;
  localparam logic [31:0] SW_ADDR         = 32'h0000_7F04;
  localparam logic [31:0] TMR_CTRL_ADDR   = 32'h0000_7F10;
  localparam logic [31:0] TMR_PRESET_ADDR = 32'h0000_7F14;
  localparam logic [31:0] TMR_COUNT_ADDR  = 32'h0000_7F18;

  localparam int EN_BIT = 0;
  localparam int AR_BIT = 1;
  localparam int ST_BIT = 2;

  typedef struct packed {
    logic ctrl;
    logic preset;
  } tmr_we_t;

endpackage

// File: rtl/sccpu_dbus_timer.sv
// Down-counting timer: CTRL/PRESET/COUNT with sticky
// expiry status driving the interrupt line.
module dbus_timer
  import sccpu_dbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  tmr_we_t     we,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl,
  output logic [31:0] preset,
  output logic [31:0] count,
  output logic        irq
);

  logic        en_q;
  logic        ar_q;
  logic        st_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        expire;

  // A PRESET write suppresses this cycle's expiry check.
  assign expire = en_q && (count_q == 32'd0) && !we.preset;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      st_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
    end else begin
      if (we.preset) begin
        preset_q <= wdata;
        count_q  <= wdata;
      end else if (en_q && count_q != 32'd0) begin
        count_q <= count_q - 32'd1;
      end else if (expire && ar_q) begin
        count_q <= preset_q;
      end
      if (we.ctrl) begin
        en_q <= wdata[EN_BIT];
        ar_q <= wdata[AR_BIT];
      end else if (expire && !ar_q) begin
        en_q <= 1'b0;
      end
      if (expire)
        st_q <= 1'b1;
      else if (we.ctrl && wdata[ST_BIT])
        st_q <= 1'b0;
    end
  end

  always_comb begin
    ctrl         = '0;
    ctrl[EN_BIT] = en_q;
    ctrl[AR_BIT] = ar_q;
    ctrl[ST_BIT] = st_q;
  end

  assign preset = preset_q;
  assign count  = count_q;
  assign irq    = st_q;

endmodule

// File: rtl/sccpu_dbus.sv
// Data-side bus stage: routes core loads/stores to the
// data RAM or the LED/switch/timer MMIO block.
module sccpu_dbus
  import sccpu_dbus_pkg::*;
#(
  parameter int RAM_AW = 10,
  parameter int LED_W  = 16,
  parameter int SW_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             irq
);

  logic [31:0]      mem [1<<RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic             ram_hit;
  logic             led_hit;
  logic             sw_hit;
  logic             ctrl_hit;
  logic             preset_hit;
  logic             count_hit;
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_q1;
  logic [SW_W-1:0]  sw_q2;
  tmr_we_t          tmr_we;
  logic [31:0]      tmr_ctrl;
  logic [31:0]      tmr_preset;
  logic [31:0]      tmr_count;

  assign ram_idx    = addr[RAM_AW+1:2];
  assign ram_hit    = (addr & ~RAM_LIMIT) == RAM_BASE;
  assign led_hit    = addr == LED_ADDR;
  assign sw_hit     = addr == SW_ADDR;
  assign ctrl_hit   = addr == TMR_CTRL_ADDR;
  assign preset_hit = addr == TMR_PRESET_ADDR;
  assign count_hit  = addr == TMR_COUNT_ADDR;

  assign tmr_we.ctrl   = we && ctrl_hit;
  assign tmr_we.preset = we && preset_hit;

  always_ff @(posedge clk) begin
    if (!rst && we && ram_hit)
      mem[ram_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
      sw_q1 <= '0;
      sw_q2 <= '0;
    end else begin
      if (we && led_hit)
        led_q <= wdata[LED_W-1:0];
      sw_q1 <= sw_in;
      sw_q2 <= sw_q1;
    end
  end

  dbus_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .we     (tmr_we),
    .wdata  (wdata),
    .ctrl   (tmr_ctrl),
    .preset (tmr_preset),
    .count  (tmr_count),
    .irq    (irq)
  );

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      ram_hit:    rdata = mem[ram_idx];
      led_hit:    rdata = {{(32-LED_W){1'b0}}, led_q};
      sw_hit:     rdata = {{(32-SW_W){1'b0}}, sw_q2};
      ctrl_hit:   rdata = tmr_ctrl;
      preset_hit: rdata = tmr_preset;
      count_hit:  rdata = tmr_count;
      default:    rdata = '0;
    endcase
  end

  assign led_out = led_q;

endmodule

// File: doc/sccpu_dbus.md
Name: sccpu_dbus

Overview:
- Data-side bus stage directly downstream of the single-cycle CPU core.
- Consumes the core's memory request: ALU result as address, store data, write strobe.
- Returns load data in the same cycle.
- Routes each access to a word-addressed data RAM or to a small MMIO block: LED register, synchronised switch input, and a down-counting timer with interrupt.

Parameters:
- RAM_AW, 10, log2 of data RAM depth in words (1024 words = 4 KiB).
- LED_W, 16, width of LED output register.
- SW_W, 16, width of switch input.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- addr  input  32  byte address from core ALU output; bits [1:0] ignored.
- wdata  input  32  store data from core.
- we  input  1  store strobe from core.
- rdata  output  32  load data to core, combinational from addr and current state.
- sw_in  input  SW_W  asynchronous board switches.
- led_out  output  LED_W  LED register contents.
- irq  output  1  timer interrupt, equals CTRL.status.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All registers clear on the clk edge where rst=1; a write presented in that cycle is discarded.
- Reset values:
  - led_out=0, irq=0, CTRL=0, PRESET=0, COUNT=0.
  - Switch synchroniser flops = 0.
  - RAM contents are not reset.
- Address map (word-aligned, full 32-bit compare on MMIO):
  - 0x0000_0000–0x0000_0FFF: RAM, index addr[RAM_AW+1:2].
  - 0x0000_7F00: LED, RW, low LED_W bits.
  - 0x0000_7F04: SW, RO, zero-extended, value of 2nd sync flop.
  - 0x0000_7F10: CTRL, RW.
    - bit0 en.
    - bit1 auto_reload.
    - bit2 status: RO to hardware set; write 1 clears, write 0 leaves unchanged.
    - Other bits read 0.
  - 0x0000_7F14: PRESET, RW, 32 bits.
  - 0x0000_7F18: COUNT, RO.
- Unmapped addresses: reads return 0; writes are ignored.
- Writes to RO registers are ignored.
- Read latency is 0 cycles (combinational), reflecting state before the current edge.
- Write latency: visible on rdata in the cycle after we.
- Read-during-write to the same address returns the old value.
- Switch path: 2-flop synchroniser; a sw_in change appears at 0x7F04 after exactly 2 clk edges.
- Timer, evaluated each edge in this priority order:
  1. rst.
  2. CPU write to PRESET: PRESET<=wdata and COUNT<=wdata. No decrement or expiry check occurs that cycle.
  3. Otherwise, if en=1 and COUNT!=0: COUNT<=COUNT-1.
  4. Otherwise, if en=1 and COUNT==0 (expiry): status<=1. If auto_reload, COUNT<=PRESET; else en<=0.
- CTRL write:
  - en and auto_reload take wdata values.
  - status cleared if wdata[2]=1.
  - On a simultaneous hardware expiry:
    - status set wins over W1C clear.
    - CPU-written en wins over hardware en clear.
- Enabling with COUNT=0 expires on the next edge.
- COUNT never wraps below 0.
- irq stays high until cleared by W1C or rst.

Decomposition:
- Shared package holds:
  - Address constants: RAM_BASE, RAM_LIMIT, LED_ADDR, SW_ADDR, TMR_CTRL_ADDR, TMR_PRESET_ADDR, TMR_COUNT_ADDR.
  - CTRL bit index constants: EN_BIT=0, AR_BIT=1, ST_BIT=2.
- One sub-module, dbus_timer: holds CTRL/PRESET/COUNT, takes decoded write enables plus wdata, and outputs ctrl, preset, count, irq.
- RAM array, decode, LED, synchroniser, and read mux stay in sccpu_dbus.

Test Plan:
- RAM: write 0xDEADBEEF to 0x0000_0010 with we=1 → next cycle, read 0x10 returns 0xDEADBEEF; read 0x0000_0013 (same word) returns the same; read 0x0000_0014 returns its own contents.
- MMIO: write 0x0000_A5A5 to 0x7F00 → led_out=0xA5A5 next cycle. Set sw_in=0x1234 → 0x7F04 reads 0 for 2 edges, then 0x0000_1234. Write to 0x7F04 → no effect. Read 0x7F20 → 0.
- One-shot timer: write PRESET=3, then CTRL=0x1 → COUNT reads 3,2,1,0 on successive cycles; irq=1 on the following edge; CTRL reads 0x4 (en cleared); COUNT stays 0.
- Auto-reload: PRESET=2, CTRL=0x3 → irq rises at expiry and COUNT reloads to 2. Write CTRL=0x7 → status cleared, en/auto_reload kept, irq=0. Later W1C in the same cycle as an expiry → irq stays 1.
- Reset mid-operation: timer running at COUNT=5 with irq=1 and LED=0xFF; assert rst for 1 cycle together with we to 0x7F00 → led_out=0, irq=0, COUNT=0, CTRL=0; write dropped. RAM data written before reset is still readable.
